// File: rtl/camera_pkg.sv
// Shared types and constants for the camera colour tracker.
package camera_pkg;

  // Per-frame match thresholds, latched at frame close and at reset.
  typedef struct packed {
    logic [7:0] cb_min;
    logic [7:0] cr_min;
    logic [7:0] y_lo;
    logic [7:0] y_hi;
  } thr_t;

  // Byte position inside a Cb, Y0, Cr, Y1 quad.
  typedef enum logic [1:0] {
    PH_CB = 2'd0,
    PH_Y0 = 2'd1,
    PH_CR = 2'd2,
    PH_Y1 = 2'd3
  } phase_e;

  localparam logic [7:0] MARK_VAL_DEF = 8'd255;
  localparam logic [7:0] DET_VAL_DEF  = 8'd254;

  // Strict unsigned window test shared by both pixels of a quad.
  function automatic logic pix_match_f(input thr_t t, input logic [7:0] cb,
                                       input logic [7:0] cr, input logic [7:0] y);
    return (cb > t.cb_min) && (cr > t.cr_min) && (y > t.y_lo) && (y < t.y_hi);
  endfunction

endpackage

// File: rtl/camera_yuv_unpack.sv
// Turns the Cb/Y0/Cr/Y1 byte stream into per-pixel valid, luma and match.
// Outputs are combinational so the top can register them with latency 1.
module camera_yuv_unpack
  import camera_pkg::*;
(
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       href,
  input  logic [7:0] byte_camera,
  input  thr_t       thr,
  output logic       pix_valid,
  output logic [7:0] pix_y,
  output logic       pix_match
);

  phase_e     phase;
  logic [7:0] cb_q;
  logic [7:0] y0_q;
  logic [7:0] cr_q;
  logic [7:0] cr_cur;

  // Pixel 0 completes on the Cr byte, pixel 1 on the Y1 byte; a frame close drops the byte.
  always_comb begin
    pix_valid = 1'b0;
    pix_y     = byte_camera;
    cr_cur    = cr_q;
    if (phase == PH_CR) begin
      pix_y  = y0_q;
      cr_cur = byte_camera;
    end
    if (href && !clear && (phase == PH_CR || phase == PH_Y1))
      pix_valid = 1'b1;
    pix_match = pix_match_f(thr, cb_q, cr_cur, pix_y);
  end

  // Phase tracking and byte capture; href low or frame close restarts the quad.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      phase <= PH_CB;
      cb_q  <= 8'd0;
      y0_q  <= 8'd0;
      cr_q  <= 8'd0;
    end else if (clear || !href) begin
      phase <= PH_CB;
    end else begin
      case (phase)
        PH_CB:   cb_q <= byte_camera;
        PH_Y0:   y0_q <= byte_camera;
        PH_CR:   cr_q <= byte_camera;
        default: ;
      endcase
      phase <= phase_e'(phase + 2'd1);
    end
  end

endmodule

// File: rtl/camera_color_tracker.sv
// Camera byte bus to frame-buffer writer with colour-run detection and
// per-frame bounding box; results are published on each vsync rising edge.
module camera_color_tracker
  import camera_pkg::*;
#(
  parameter int         H_ACTIVE = 640,
  parameter int         V_ACTIVE = 480,
  parameter int         ADDR_W   = 20,
  parameter int         RUN_MIN  = 20,
  parameter logic [7:0] MARK_VAL = MARK_VAL_DEF,
  parameter logic [7:0] DET_VAL  = DET_VAL_DEF
) (
  input  logic                          pclk,
  input  logic                          reset_n,
  input  logic                          vsync,
  input  logic                          href,
  input  logic [7:0]                    byte_camera,
  input  logic [7:0]                    cb_min,
  input  logic [7:0]                    cr_min,
  input  logic [7:0]                    y_lo,
  input  logic [7:0]                    y_hi,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [7:0]                    wr_data,
  output logic                          frame_done,
  output logic                          found,
  output logic [$clog2(H_ACTIVE)-1:0]   det_x,
  output logic [$clog2(V_ACTIVE)-1:0]   det_y,
  output logic [$clog2(H_ACTIVE)-1:0]   bbox_x0,
  output logic [$clog2(H_ACTIVE)-1:0]   bbox_x1,
  output logic [$clog2(V_ACTIVE)-1:0]   bbox_y0,
  output logic [$clog2(V_ACTIVE)-1:0]   bbox_y1,
  output logic                          overflow
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  // Counters carry one extra bit so they can sit at H_ACTIVE/V_ACTIVE when saturated.
  localparam logic [XW:0] H_LIM   = (XW+1)'(H_ACTIVE);
  localparam logic [YW:0] V_LIM   = (YW+1)'(V_ACTIVE);
  localparam logic [XW:0] X_ONE   = (XW+1)'(1);
  localparam logic [YW:0] Y_ONE   = (YW+1)'(1);
  localparam logic [7:0]  RUN_LIM = 8'(RUN_MIN);

  thr_t          thr;
  logic          vsync_q;
  logic          href_q;
  logic          vs_rise;
  logic          href_fall;

  logic          pix_valid;
  logic [7:0]    pix_y;
  logic          pix_match;

  logic [XW:0]   x_cnt;
  logic [YW:0]   y_cnt;
  logic [7:0]    run_cnt;
  logic          line_has_pix;

  logic          found_w;
  logic          ovf_w;
  logic [XW-1:0] det_x_w;
  logic [YW-1:0] det_y_w;
  logic [XW-1:0] min_x_w;
  logic [XW-1:0] max_x_w;
  logic [YW-1:0] min_y_w;
  logic [YW-1:0] max_y_w;

  logic          in_range;
  logic [7:0]    run_next;
  logic          qual;
  logic [XW-1:0] x_idx;
  logic [YW-1:0] y_idx;

  assign vs_rise   = vsync & ~vsync_q;
  assign href_fall = href_q & ~href;

  camera_yuv_unpack u_unpack (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .clear       (vs_rise),
    .href        (href),
    .byte_camera (byte_camera),
    .thr         (thr),
    .pix_valid   (pix_valid),
    .pix_y       (pix_y),
    .pix_match   (pix_match)
  );

  // Per-pixel run and qualification decisions for the pixel completing this cycle.
  always_comb begin
    in_range = (x_cnt < H_LIM) && (y_cnt < V_LIM);
    x_idx    = x_cnt[XW-1:0];
    y_idx    = y_cnt[YW-1:0];
    run_next = 8'd0;
    if (pix_match)
      run_next = (run_cnt == 8'hFF) ? 8'hFF : run_cnt + 8'd1;
    qual = pix_valid && pix_match && in_range && (run_next >= RUN_LIM);
  end

  // Edge detectors and threshold latch (reloaded while in reset and at each frame close).
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      thr     <= '{cb_min: cb_min, cr_min: cr_min, y_lo: y_lo, y_hi: y_hi};
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      if (vs_rise)
        thr <= '{cb_min: cb_min, cr_min: cr_min, y_lo: y_lo, y_hi: y_hi};
    end
  end

  // Saturating x/y coordinates and the in-line run counter.
  always_ff @(posedge pclk) begin
    if (!reset_n || vs_rise) begin
      x_cnt        <= '0;
      y_cnt        <= '0;
      run_cnt      <= 8'd0;
      line_has_pix <= 1'b0;
    end else if (href_fall) begin
      x_cnt        <= '0;
      run_cnt      <= 8'd0;
      line_has_pix <= 1'b0;
      if (line_has_pix && y_cnt != V_LIM)
        y_cnt <= y_cnt + Y_ONE;
    end else if (pix_valid) begin
      run_cnt      <= run_next;
      line_has_pix <= 1'b1;
      if (x_cnt != H_LIM)
        x_cnt <= x_cnt + X_ONE;
    end
  end

  // Working frame statistics: first detection, bounding box and sticky overflow.
  always_ff @(posedge pclk) begin
    if (!reset_n || vs_rise) begin
      found_w <= 1'b0;
      ovf_w   <= 1'b0;
      det_x_w <= '0;
      det_y_w <= '0;
      min_x_w <= '1;
      max_x_w <= '0;
      min_y_w <= '1;
      max_y_w <= '0;
    end else if (pix_valid) begin
      if (!in_range)
        ovf_w <= 1'b1;
      if (qual) begin
        found_w <= 1'b1;
        if (!found_w) begin
          det_x_w <= x_idx;
          det_y_w <= y_idx;
        end
        if (x_idx < min_x_w) min_x_w <= x_idx;
        if (x_idx > max_x_w) max_x_w <= x_idx;
        if (y_idx < min_y_w) min_y_w <= y_idx;
        if (y_idx > max_y_w) max_y_w <= y_idx;
      end
    end
  end

  // Frame-buffer write port, one strobe per in-range pixel.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'd0;
    end else begin
      wr_en <= pix_valid && in_range;
      if (pix_valid && in_range) begin
        wr_addr <= ADDR_W'(y_cnt) * ADDR_W'(H_ACTIVE) + ADDR_W'(x_cnt);
        if (!pix_match)
          wr_data <= pix_y >> 1;
        else if (qual && !found_w)
          wr_data <= DET_VAL;
        else
          wr_data <= MARK_VAL;
      end
    end
  end

  // Publish results at frame close; zero det/bbox when nothing qualified.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
      found      <= 1'b0;
      overflow   <= 1'b0;
      det_x      <= '0;
      det_y      <= '0;
      bbox_x0    <= '0;
      bbox_x1    <= '0;
      bbox_y0    <= '0;
      bbox_y1    <= '0;
    end else begin
      frame_done <= vs_rise;
      if (vs_rise) begin
        found    <= found_w;
        overflow <= ovf_w;
        if (found_w) begin
          det_x   <= det_x_w;
          det_y   <= det_y_w;
          bbox_x0 <= min_x_w;
          bbox_x1 <= max_x_w;
          bbox_y0 <= min_y_w;
          bbox_y1 <= max_y_w;
        end else begin
          det_x   <= '0;
          det_y   <= '0;
          bbox_x0 <= '0;
          bbox_x1 <= '0;
          bbox_y0 <= '0;
          bbox_y1 <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_color_tracker.sv
// Directed bench for camera_color_tracker: a 40x8 instance for most scenarios
// and an 8x4 instance for horizontal overflow.
module tb_camera_color_tracker;

  logic       pclk = 1'b0;
  logic       reset_n;
  logic       vsync;
  logic       href;
  logic [7:0] byte_camera;
  logic [7:0] cb_min, cr_min, y_lo, y_hi;

  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done, found, overflow;
  logic [5:0] det_x, bbox_x0, bbox_x1;
  logic [2:0] det_y, bbox_y0, bbox_y1;

  logic       o_wr_en;
  logic [5:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_frame_done, o_found, o_overflow;
  logic [2:0] o_det_x, o_bbox_x0, o_bbox_x1;
  logic [1:0] o_det_y, o_bbox_y0, o_bbox_y1;

  int vec_cnt = 0;
  int err_cnt = 0;
  int fd_cnt = 0;
  int o_fd_cnt = 0;
  int o_wr_cnt = 0;
  int o_wr_max = 0;
  int o_wr_bad = 0;
  int log_addr[$];
  int log_data[$];
  logic [7:0] line_y [0:63];

  camera_color_tracker #(.H_ACTIVE(40), .V_ACTIVE(8), .ADDR_W(10), .RUN_MIN(20)) dut (
    .pclk(pclk), .reset_n(reset_n), .vsync(vsync), .href(href), .byte_camera(byte_camera),
    .cb_min(cb_min), .cr_min(cr_min), .y_lo(y_lo), .y_hi(y_hi),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .found(found), .det_x(det_x), .det_y(det_y), .bbox_x0(bbox_x0), .bbox_x1(bbox_x1),
    .bbox_y0(bbox_y0), .bbox_y1(bbox_y1), .overflow(overflow)
  );

  camera_color_tracker #(.H_ACTIVE(8), .V_ACTIVE(4), .ADDR_W(6), .RUN_MIN(20)) dut_ovf (
    .pclk(pclk), .reset_n(reset_n), .vsync(vsync), .href(href), .byte_camera(byte_camera),
    .cb_min(cb_min), .cr_min(cr_min), .y_lo(y_lo), .y_hi(y_hi),
    .wr_en(o_wr_en), .wr_addr(o_wr_addr), .wr_data(o_wr_data), .frame_done(o_frame_done),
    .found(o_found), .det_x(o_det_x), .det_y(o_det_y), .bbox_x0(o_bbox_x0), .bbox_x1(o_bbox_x1),
    .bbox_y0(o_bbox_y0), .bbox_y1(o_bbox_y1), .overflow(o_overflow)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (wr_en) begin
      log_addr.push_back(int'(wr_addr));
      log_data.push_back(int'(wr_data));
    end
    if (frame_done) fd_cnt++;
    if (o_frame_done) o_fd_cnt++;
    if (o_wr_en) begin
      o_wr_cnt++;
      if (int'(o_wr_addr) > o_wr_max) o_wr_max = int'(o_wr_addr);
      if (o_wr_data != 8'd255) o_wr_bad++;
    end
  end

  function automatic int la(input int i);
    return (i < log_addr.size()) ? log_addr[i] : -1;
  endfunction

  function automatic int ld(input int i);
    return (i < log_data.size()) ? log_data[i] : -1;
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    href        = 1'b1;
    byte_camera = b;
    tick();
  endtask

  // n pixels (even) using line_y[] lumas, Cb=150 and Cr=160, then href low.
  task automatic send_line(input int n);
    for (int q = 0; q < n / 2; q++) begin
      send_byte(8'd150);
      send_byte(line_y[2*q]);
      send_byte(8'd160);
      send_byte(line_y[2*q+1]);
    end
    href = 1'b0;
    tick();
    tick();
  endtask

  task automatic close_frame();
    vsync = 1'b1;
    repeat (4) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    fd_cnt   = 0;
    o_fd_cnt = 0;
    o_wr_cnt = 0;
    o_wr_max = 0;
    o_wr_bad = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    byte_camera = 8'd0;
    cb_min = 8'd139; cr_min = 8'd145; y_lo = 8'd64; y_hi = 8'd190;
    repeat (3) tick();
    vec_cnt++;
    if ({wr_en, frame_done, found, overflow} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_flags: got %b, want 0000", {wr_en, frame_done, found, overflow});
    end
    vec_cnt++;
    if ({wr_addr, wr_data, det_x, det_y, bbox_x0, bbox_x1, bbox_y0, bbox_y1} !== '0) begin
      err_cnt++;
      $display("FAIL reset_values: addr %0d data %0d det %0d,%0d, want all 0", wr_addr, wr_data, det_x, det_y);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_quad_unpack();
    clear_logs();
    send_byte(8'd150);
    send_byte(8'd100);
    send_byte(8'd160);
    vec_cnt++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'd0, 8'd255}) begin
      err_cnt++;
      $display("FAIL quad_px0: en %b addr %0d data %0d, want 1 0 255", wr_en, wr_addr, wr_data);
    end
    send_byte(8'd40);
    vec_cnt++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'd1, 8'd20}) begin
      err_cnt++;
      $display("FAIL quad_px1: en %b addr %0d data %0d, want 1 1 20", wr_en, wr_addr, wr_data);
    end
    href = 1'b0;
    tick();
    vec_cnt++;
    if (wr_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL quad_single_strobe: wr_en %b, want 0", wr_en);
    end
    close_frame();
    vec_cnt++;
    if (fd_cnt !== 1 || found !== 1'b0) begin
      err_cnt++;
      $display("FAIL quad_close: frame_done pulses %0d found %b, want 1 0", fd_cnt, found);
    end
  endtask

  task automatic test_run_detect();
    for (int i = 0; i < 64; i++) line_y[i] = 8'd40;
    for (int l = 0; l < 3; l++) send_line(2);
    clear_logs();
    for (int i = 10; i <= 34; i++) line_y[i] = 8'd100;
    send_line(36);
    vec_cnt++;
    if (log_data.size() !== 36) begin
      err_cnt++;
      $display("FAIL run_pixel_count: got %0d, want 36", log_data.size());
    end
    vec_cnt++;
    if (la(29) !== 149 || ld(29) !== 254) begin
      err_cnt++;
      $display("FAIL run_det_pixel: addr %0d data %0d, want 149 254", la(29), ld(29));
    end
    vec_cnt++;
    if (ld(28) !== 255 || ld(30) !== 255 || ld(34) !== 255 || ld(9) !== 20 || ld(35) !== 20) begin
      err_cnt++;
      $display("FAIL run_neighbours: x9 %0d x28 %0d x30 %0d x34 %0d x35 %0d, want 20 255 255 255 20",
               ld(9), ld(28), ld(30), ld(34), ld(35));
    end
    close_frame();
    vec_cnt++;
    if (found !== 1'b1 || det_x !== 6'd29 || det_y !== 3'd3) begin
      err_cnt++;
      $display("FAIL run_det: found %b det (%0d,%0d), want 1 (29,3)", found, det_x, det_y);
    end
    vec_cnt++;
    if (bbox_x0 !== 6'd29 || bbox_x1 !== 6'd34 || bbox_y0 !== 3'd3 || bbox_y1 !== 3'd3) begin
      err_cnt++;
      $display("FAIL run_bbox: x %0d..%0d y %0d..%0d, want 29..34 3..3", bbox_x0, bbox_x1, bbox_y0, bbox_y1);
    end
  endtask

  task automatic test_below_threshold();
    int n254;
    clear_logs();
    for (int i = 0; i < 64; i++) line_y[i] = 8'd100;
    line_y[19] = 8'd40;
    line_y[39] = 8'd40;
    send_line(40);
    n254 = 0;
    foreach (log_data[i]) if (log_data[i] == 254) n254++;
    vec_cnt++;
    if (n254 !== 0 || log_data.size() !== 40) begin
      err_cnt++;
      $display("FAIL below_pixels: det pixels %0d count %0d, want 0 40", n254, log_data.size());
    end
    close_frame();
    vec_cnt++;
    if (found !== 1'b0 || {det_x, det_y, bbox_x0, bbox_x1, bbox_y0, bbox_y1} !== '0) begin
      err_cnt++;
      $display("FAIL below_result: found %b det (%0d,%0d) bbox x1 %0d, want 0", found, det_x, det_y, bbox_x1);
    end
    vec_cnt++;
    if (overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL below_full_line_ovf: overflow %b, want 0", overflow);
    end
  endtask

  task automatic test_overflow();
    clear_logs();
    for (int i = 0; i < 64; i++) line_y[i] = 8'd100;
    send_line(10);
    vec_cnt++;
    if (o_wr_cnt !== 8 || o_wr_max >= 8 || o_wr_bad !== 0) begin
      err_cnt++;
      $display("FAIL ovf_writes: pulses %0d max addr %0d bad data %0d, want 8 <8 0", o_wr_cnt, o_wr_max, o_wr_bad);
    end
    close_frame();
    vec_cnt++;
    if (o_overflow !== 1'b1 || o_fd_cnt !== 1) begin
      err_cnt++;
      $display("FAIL ovf_flag: overflow %b frame_done %0d, want 1 1", o_overflow, o_fd_cnt);
    end
    vec_cnt++;
    if (o_found !== 1'b0 || {o_det_x, o_det_y, o_bbox_x0, o_bbox_x1, o_bbox_y0, o_bbox_y1} !== '0) begin
      err_cnt++;
      $display("FAIL ovf_no_det: found %b det_x %0d, want 0 0", o_found, o_det_x);
    end
    vec_cnt++;
    if (overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL ovf_wide_instance: overflow %b, want 0", overflow);
    end
    close_frame();
    vec_cnt++;
    if (o_overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL ovf_clears_next_frame: overflow %b, want 0", o_overflow);
    end
  endtask

  task automatic test_partial_quad();
    clear_logs();
    send_byte(8'd150);
    send_byte(8'd100);
    send_byte(8'd160);
    href = 1'b0;
    tick();
    tick();
    vec_cnt++;
    if (log_data.size() !== 1 || la(0) !== 0 || ld(0) !== 255) begin
      err_cnt++;
      $display("FAIL partial_one_pixel: count %0d addr %0d data %0d, want 1 0 255", log_data.size(), la(0), ld(0));
    end
    line_y[0] = 8'd100;
    line_y[1] = 8'd200;
    send_line(2);
    vec_cnt++;
    if (la(1) !== 40 || ld(1) !== 255 || la(2) !== 41 || ld(2) !== 100) begin
      err_cnt++;
      $display("FAIL partial_next_line: %0d/%0d %0d/%0d, want 40/255 41/100", la(1), ld(1), la(2), ld(2));
    end
    close_frame();
  endtask

  task automatic test_reset_collision();
    for (int i = 0; i < 64; i++) line_y[i] = 8'd100;
    send_line(22);
    close_frame();
    vec_cnt++;
    if (found !== 1'b1 || det_x !== 6'd19 || bbox_x1 !== 6'd21) begin
      err_cnt++;
      $display("FAIL pre_reset_result: found %b det_x %0d x1 %0d, want 1 19 21", found, det_x, bbox_x1);
    end
    clear_logs();
    for (int q = 0; q < 3; q++) begin
      send_byte(8'd150); send_byte(8'd100); send_byte(8'd160); send_byte(8'd100);
    end
    reset_n = 1'b0;
    send_byte(8'd150);
    send_byte(8'd100);
    vec_cnt++;
    if ({wr_en, frame_done, found, overflow, det_x, det_y, bbox_x0, bbox_x1, bbox_y0, bbox_y1} !== '0) begin
      err_cnt++;
      $display("FAIL midframe_reset_outputs: found %b det_x %0d x1 %0d wr_en %b, want 0", found, det_x, bbox_x1, wr_en);
    end
    href = 1'b0;
    reset_n = 1'b1;
    repeat (3) tick();
    vec_cnt++;
    if (fd_cnt !== 0) begin
      err_cnt++;
      $display("FAIL midframe_reset_no_done: frame_done pulses %0d, want 0", fd_cnt);
    end
    clear_logs();
    send_byte(8'd150);
    send_byte(8'd100);
    vsync = 1'b1;
    send_byte(8'd160);
    vec_cnt++;
    if (wr_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL collision_byte_dropped: wr_en %b, want 0", wr_en);
    end
    href = 1'b0;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    vec_cnt++;
    if (fd_cnt !== 1 || log_data.size() !== 0 || found !== 1'b0) begin
      err_cnt++;
      $display("FAIL collision_close: pulses %0d writes %0d found %b, want 1 0 0", fd_cnt, log_data.size(), found);
    end
    line_y[0] = 8'd100;
    line_y[1] = 8'd40;
    send_line(2);
    vec_cnt++;
    if (la(0) !== 0 || ld(0) !== 255 || la(1) !== 1 || ld(1) !== 20) begin
      err_cnt++;
      $display("FAIL collision_next_line: %0d/%0d %0d/%0d, want 0/255 1/20", la(0), ld(0), la(1), ld(1));
    end
  endtask

  initial begin
    test_reset();
    test_quad_unpack();
    test_run_detect();
    test_below_threshold();
    test_overflow();
    test_partial_quad();
    test_reset_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/camera_color_tracker.md
# camera_color_tracker

Parametrised successor to the single-frame color detector, sitting between the camera byte bus and frame-buffer memory. It unpacks YCbCr 4:2:2 bytes into one 8-bit output pixel per camera pixel, with a single write address per pixel. Thresholds are set at runtime and latched per frame. Over each frame it tracks the first qualifying color run and the bounding box of all qualifying runs, and publishes results on a frame-done pulse.

## Interface
Parameters:
- `H_ACTIVE`, 640: pixels per line.
- `V_ACTIVE`, 480: lines per frame.
- `ADDR_W`, 20: write-address width; must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE.
- `RUN_MIN`, 20: consecutive matched pixels in one line required to qualify; range 1..255.
- `MARK_VAL`, 255: output value for matched pixels.
- `DET_VAL`, 254: output value for the detection pixel.

Ports:
- `pclk` in 1: camera pixel clock; the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `vsync` in 1: high during vertical blanking; its rising edge closes the frame.
- `href` in 1: line-active qualifier.
- `byte_camera` in 8: byte stream, order Cb, Y0, Cr, Y1.
- `cb_min`, `cr_min`, `y_lo`, `y_hi` in 8 each: match thresholds.
- `wr_en` out 1: pixel write strobe.
- `wr_addr` out ADDR_W: y·H_ACTIVE + x.
- `wr_data` out 8: output pixel.
- `frame_done` out 1: one-cycle pulse.
- `found` out 1: a qualifying run was seen in the last closed frame.
- `det_x`, `det_y` out clog2(H_ACTIVE), clog2(V_ACTIVE): position of the first qualifying pixel.
- `bbox_x0`, `bbox_x1`, `bbox_y0`, `bbox_y1` out (x/y widths): bounding box of qualifying pixels.
- `overflow` out 1: the last closed frame exceeded H_ACTIVE or V_ACTIVE.

## Operation
- **Byte phase** (0..3): advances on each `pclk` with `href`=1.
  - `href`=0 forces phase 0.
  - A partial quad is discarded, except that pixel 0 is already emitted once phase 2 has been sampled.
- **Pixel 0**: evaluated when the Cr byte (phase 2) is sampled, using Cb, Y0 and Cr.
- **Pixel 1**: evaluated when the Y1 byte (phase 3) is sampled, using Cb, Cr and Y1.
- **Match rule**: cb > cb_min, cr > cr_min, y > y_lo and y < y_hi, all strict and unsigned.
- **Output data**: matched pixels output MARK_VAL; unmatched pixels output y>>1, so at most 127.
- **Threshold latch**: thresholds are captured on the vsync rising edge and at reset release; they stay stable for the whole frame.
- **Coordinates**:
  - x increments per emitted pixel and clears on the `href` falling edge.
  - y increments on each `href` falling edge that had at least one pixel.
- **Overflow**: any pixel with x ≥ H_ACTIVE or y ≥ V_ACTIVE does not assert `wr_en` and sets the sticky frame overflow flag. Counters saturate and do not wrap.
- **Run counter**: 8-bit, saturating at 255.
  - Increments on a matched pixel.
  - Clears on an unmatched pixel and on line end.
- **Qualifying pixel**: a matched pixel whose run count after the increment is ≥ RUN_MIN.
- **First qualifying pixel in the frame**: its `wr_data` is DET_VAL instead of MARK_VAL, and its x/y are recorded.
- **Bounding box**: per-frame min/max over all qualifying pixels. Working min registers are initialised to all-ones at frame start; working max registers are initialised to 0.
- **Frame close** (vsync rising edge):
  - Drive `found`, det, bbox and `overflow` from the working registers.
  - Pulse `frame_done`.
  - Clear the working registers, x, y, phase and run count.
  - If nothing qualified, `found`=0, det and bbox outputs are 0, and `overflow` still updates.
- **vsync vs. href**: a vsync rising edge coincident with `href`=1 takes priority; the byte in that cycle is dropped.

## Timing
- `wr_en`/`wr_addr`/`wr_data` are registered and valid on the cycle after the last needed byte is sampled (latency 1 from Cr or Y1).
- `wr_en` is high for exactly one cycle per pixel, giving at most 2 pulses per 4 bytes.
- Result outputs update in the same registered cycle as `frame_done`=1 and hold until the next close.
- vsync edge detection uses one internal register, so the close occurs 1 cycle after vsync is first sampled high.
- Reset (`reset_n`=0 at a `pclk` edge): all outputs 0, phase 0, counters 0, thresholds reloaded. Reset mid-line abandons the frame and does not produce a `frame_done`.

## Structure
- `camera_pkg` holds:
  - the threshold struct (cb_min, cr_min, y_lo, y_hi);
  - the phase enum (PH_CB, PH_Y0, PH_CR, PH_Y1);
  - the default MARK_VAL/DET_VAL constants.
- Sub-module `camera_yuv_unpack`: phase tracking, byte capture and match evaluation; emits pixel-valid, y and match. The top holds coordinates, run detection, bbox and frame close.

## Test plan
- **Quad unpack**: one line of 4 bytes Cb=150, Y0=100, Cr=160, Y1=40, thresholds 139/145/64/190 → `wr_data` 255 then 20 at addresses 0 and 1.
- **Run detection**: RUN_MIN=20, a line with 25 matched pixels starting at x=10 on y=3 → pixel x=29 outputs 254; after vsync, `found`=1, det=(29,3), bbox x0=29, x1=34, y0=y1=3.
- **Below-threshold run**: 19 matched pixels, then 1 unmatched, then 19 matched → `found`=0 at frame close; bbox outputs 0.
- **Overflow**: H_ACTIVE=8 and a 10-pixel line → 8 `wr_en` pulses, `overflow`=1 at frame close, `wr_addr` never ≥ 8 on that line.
- **Partial quad and href drop**: `href` falls after phase 2 → exactly one pixel is emitted, and the next line starts at phase 0 with x=0.
- **Reset and vsync/href collision**: `reset_n` low mid-frame → all outputs 0 and no `frame_done`; a vsync rising edge with `href`=1 → that byte dropped and `frame_done` pulses once.
